// File: rtl/pc_seq_pkg.sv
// pc_seq shared types: sequencer states and control-op encoding.
// The op picker resolves overlapping control requests by priority.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DONE  = 2'd2,
    ST_FAULT = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    OP_SEQ  = 3'd0,
    OP_REL  = 3'd1,
    OP_BR   = 3'd2,
    OP_CALL = 3'd3,
    OP_RET  = 3'd4
  } op_e;

  function automatic op_e pick_op(
    input logic ret_en,
    input logic call_en,
    input logic br_en,
    input logic br_cond,
    input logic rel_en
  );
    op_e op;
    priority case (1'b1)
      ret_en:            op = OP_RET;
      call_en:           op = OP_CALL;
      (br_en & br_cond): op = OP_BR;
      rel_en:            op = OP_REL;
      default:           op = OP_SEQ;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/pc_ret_stack.sv
// Return-address stack for pc_seq.
// Overflow/underflow are refused here; the caller faults on full/empty.
module pc_ret_stack #(
  parameter int D  = 12,
  parameter int SD = 4
) (
  input  logic         clk,
  input  logic         push,
  input  logic         pop,
  input  logic         clr,
  input  logic [D-1:0] din,
  output logic [D-1:0] top,
  output logic         full,
  output logic         empty
);

  localparam int PW = $clog2(SD + 1);
  localparam int AW = (SD > 1) ? $clog2(SD) : 1;

  logic [PW-1:0] sp_q, sp_d;
  logic [D-1:0]  mem_q [SD];
  logic [D-1:0]  mem_d [SD];
  logic [AW-1:0] wr_ix;
  logic [AW-1:0] rd_ix;

  assign full  = (sp_q == PW'(SD));
  assign empty = (sp_q == '0);
  assign wr_ix = AW'(sp_q);
  assign rd_ix = AW'(sp_q - 1'b1);
  assign top   = empty ? '0 : mem_q[rd_ix];

  always_comb begin
    sp_d  = sp_q;
    mem_d = mem_q;
    if (clr) begin
      sp_d = '0;
    end else if (push && !full) begin
      mem_d[wr_ix] = din;
      sp_d         = sp_q + 1'b1;
    end else if (pop && !empty) begin
      sp_d = sp_q - 1'b1;
    end
  end

  // Entries need no reset: sp gates every read.
  always_ff @(posedge clk) begin
    sp_q  <= sp_d;
    mem_q <= mem_d;
  end

endmodule

// File: rtl/pc_seq.sv
// Program sequencer: run handshake, branch LUT, call/return stack.
// Halt address takes precedence over stall and control inputs.
module pc_seq
  import pc_seq_pkg::*;
#(
  parameter int D         = 12,
  parameter int LW        = 4,
  parameter int SD        = 4,
  parameter int HALT_ADDR = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  input  logic [D-1:0]  start_addr,
  input  logic          stall,
  input  logic          br_en,
  input  logic          br_cond,
  input  logic [LW-1:0] br_idx,
  input  logic          rel_en,
  input  logic [D-1:0]  rel_off,
  input  logic          call_en,
  input  logic          ret_en,
  input  logic          lut_wr_en,
  input  logic [LW-1:0] lut_wr_idx,
  input  logic [D-1:0]  lut_wr_dat,
  output logic [D-1:0]  prog_ctr,
  output logic          running,
  output logic          done,
  output logic          stk_err
);

  localparam int          NL   = 1 << LW;
  localparam logic [D-1:0] HALT = D'(HALT_ADDR);

  state_e       state_q, state_d;
  logic [D-1:0] pc_q, pc_d;
  logic [D-1:0] lut_q [NL];
  logic [D-1:0] lut_d [NL];

  op_e          op;
  logic         req_acc;
  logic         run_go;
  logic [D-1:0] pc_inc;
  logic [D-1:0] lut_tgt;
  logic         stk_push;
  logic         stk_pop;
  logic         stk_clr;
  logic [D-1:0] stk_top;
  logic         stk_full;
  logic         stk_empty;

  assign op      = pick_op(ret_en, call_en, br_en, br_cond, rel_en);
  assign req_acc = req && (state_q != ST_RUN);
  assign run_go  = (state_q == ST_RUN) && (pc_q != HALT) && !stall;
  assign pc_inc  = pc_q + 1'b1;
  assign lut_tgt = lut_q[br_idx];

  assign stk_push = run_go && (op == OP_CALL) && !stk_full;
  assign stk_pop  = run_go && (op == OP_RET) && !stk_empty;
  assign stk_clr  = !reset || req_acc;

  pc_ret_stack #(
    .D  (D),
    .SD (SD)
  ) u_stk (
    .clk   (clk),
    .push  (stk_push),
    .pop   (stk_pop),
    .clr   (stk_clr),
    .din   (pc_inc),
    .top   (stk_top),
    .full  (stk_full),
    .empty (stk_empty)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    unique case (state_q)
      ST_RUN: begin
        if (pc_q == HALT) begin
          state_d = ST_DONE;
        end else if (!stall) begin
          unique case (op)
            OP_RET: begin
              if (stk_empty) state_d = ST_FAULT;
              else           pc_d    = stk_top;
            end
            OP_CALL: begin
              if (stk_full) state_d = ST_FAULT;
              else          pc_d    = lut_tgt;
            end
            OP_BR:   pc_d = lut_tgt;
            OP_REL:  pc_d = pc_q + rel_off;
            default: pc_d = pc_inc;
          endcase
        end
      end
      default: begin
        if (req) begin
          pc_d    = start_addr;
          state_d = ST_RUN;
        end
      end
    endcase
  end

  // LUT reads above see lut_q, so a same-cycle write is not forwarded.
  always_comb begin
    lut_d = lut_q;
    if (lut_wr_en) lut_d[lut_wr_idx] = lut_wr_dat;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      lut_q   <= '{default: '0};
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      lut_q   <= lut_d;
    end
  end

  assign prog_ctr = pc_q;
  assign running  = (state_q == ST_RUN);
  assign done     = (state_q == ST_DONE);
  assign stk_err  = (state_q == ST_FAULT);

endmodule
